contador_direccion_ir: RTL
==========================

// Module: contador_direccion_ir
// PURPOSE
// - Sequencer for the two debounced IR barrier channels (antirrebote outputs) at a doorway.
// - Decodes crossing order A->AB->B (entry) / B->AB->A (exit), maintains saturating occupancy
//   count, flags aborted/invalid/timed-out crossings. Feeds display/alarm logic of the counter.
// PARAMETERS
// - COUNT_W         8           width of occupancy count
// - MAX_COUNT       99          saturation ceiling (<= 2**COUNT_W-1)
// - TIMEOUT_CYCLES  50_000_000  max cycles in one crossing state (1 s @ 50 MHz), >= 2
// - TMR_W           26          timeout counter width, 2**TMR_W > TIMEOUT_CYCLES
// PORTS
// - clk          in   1        system clock, 50 MHz
// - rst          in   1        asynchronous, active-high reset
// - sensor_a     in   1        debounced IR A (outer side), 1 = beam broken, synchronous to clk
// - sensor_b     in   1        debounced IR B (inner side), 1 = beam broken
// - clear        in   1        synchronous count clear, level-sampled
// - count        out  COUNT_W  current occupancy
// - entry_pulse  out  1        1-cycle pulse on completed entry
// - exit_pulse   out  1        1-cycle pulse on completed exit
// - error_pulse  out  1        1-cycle pulse on invalid sequence or timeout
// - busy         out  1        1 whenever state != IDLE
// - full / empty out  1        count == MAX_COUNT / count == 0
// BEHAVIOUR
// - Reset: state=IDLE, count=0, timer=0, all pulses 0, busy=0, full=0, empty=1.
// - Registered FSM; inputs sampled as s={sensor_a,sensor_b} every rising edge; outputs registered.
// - IDLE: 10->E1; 01->X1; 11->ERR (error); 00 stay.
// - E1: 10 stay; 11->E2; 00->IDLE (backed out, no pulse); 01->ERR.
// - E2: 11 stay; 01->E3; 10->E1; 00->ERR.
// - E3: 01 stay; 11->E2; 00->IDLE + entry; 10->ERR.
// - X1/X2/X3: mirror of E1/E2/E3 with A,B swapped; X3 on 00 -> IDLE + exit.
// - ERR: stays until s==00, then IDLE; no count change, no further error pulses.
// - Every transition into ERR asserts error_pulse exactly one cycle.
// - Timer: cleared on every state change and in IDLE/ERR; increments each cycle a crossing
//   state is held. Held cycle with timer==TIMEOUT_CYCLES-1 -> ERR + error_pulse.
// - Entry: edge sampling 00 in E3 sets entry_pulse=1 and count+1 on that same edge (visible
//   one cycle after the sample). Exit likewise with count-1.
// - Saturation: entry at MAX_COUNT -> count holds, entry_pulse still asserted; exit at 0 ->
//   count holds 0, exit_pulse still asserted. No wrap-around ever.
// - clear=1: count<=0 on that edge; clear wins over a simultaneous entry/exit (pulse still
//   asserted). FSM unaffected by clear.
// - entry_pulse, exit_pulse, error_pulse mutually exclusive in any cycle.
// - full/empty derived from registered count (same cycle as count).
// - rst mid-crossing: immediate IDLE, count=0, pending crossing discarded, no pulse.
// STRUCTURE
// - Shared include ir_defs.vh: state encodings (IDLE,E1,E2,E3,X1,X2,X3,ERR; 3-bit localparams)
//   and the 50 MHz clock constant used to derive TIMEOUT_CYCLES.
// - One sub-module: ocupacion_contador (saturating up/down counter with clear, MAX_COUNT,
//   full/empty). FSM + timer stay in this module.
// - Debouncing is external; this block never instantiates antirrebote.
// TESTING  (bench overrides TIMEOUT_CYCLES=20, MAX_COUNT=3; sensor steps held >=3 cycles)
// - Entry 00,10,11,01,00 -> entry_pulse 1 cycle, count 0->1, busy 1 during sequence.
// - Exit 00,01,11,10,00 from count=1 -> exit_pulse, count 1->0; repeat exit -> pulse, count 0.
// - Four entries -> count 1,2,3,3; full=1 after 3rd; 4th gives entry_pulse, count stays 3.
// - Invalid 00,11 from IDLE -> error_pulse once, busy until 00, count unchanged.
// - Backout 10,00 -> IDLE, no pulse; partial 10,11,10,11,01,00 -> single entry.
// - Hold 10 for 25 cycles -> error_pulse at 20th held cycle, ERR until 00; rst asserted in
//   E2 -> IDLE, count 0 asynchronously; clear with completing entry -> count 0, entry_pulse 1.

Source files
------------

// File: rtl/contador_direccion_ir_pkg.sv
// -----------------------------------------------------------------------------
// contador_direccion_ir_pkg
// Shared definitions for the doorway direction counter:
//   - system clock rate, used to derive the default crossing timeout (1 s)
//   - FSM state encodings (3-bit): IDLE, E1..E3 (entry), X1..X3 (exit), ERR
//   - sensor pattern encoding for s = {sensor_a, sensor_b}
//   - helper telling whether a state is one of the six crossing states
// No ports (package).
// -----------------------------------------------------------------------------
package contador_direccion_ir_pkg;

  // 50 MHz system clock; one second of clock cycles is the default timeout.
  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned TIMEOUT_1S = CLK_HZ;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E1   = 3'd1,  // A broken only, entering
    ST_E2   = 3'd2,  // both broken, entering
    ST_E3   = 3'd3,  // B broken only, entering
    ST_X1   = 3'd4,  // B broken only, leaving
    ST_X2   = 3'd5,  // both broken, leaving
    ST_X3   = 3'd6,  // A broken only, leaving
    ST_ERR  = 3'd7   // invalid sequence or timeout, wait for both beams clear
  } state_t;

  // Pattern {sensor_a, sensor_b}; 1 = beam broken.
  typedef enum logic [1:0] {
    S_NONE = 2'b00,
    S_B    = 2'b01,
    S_A    = 2'b10,
    S_AB   = 2'b11
  } sens_t;

  // Crossing states are the only ones where the dwell timer runs.
  function automatic logic is_crossing(input state_t st);
    return !(st inside {ST_IDLE, ST_ERR});
  endfunction

endpackage

// File: rtl/ocupacion_contador.sv
// -----------------------------------------------------------------------------
// ocupacion_contador
// Saturating up/down occupancy counter with synchronous clear.
// Clear has priority over increment/decrement; increment at MAX_COUNT and
// decrement at 0 are absorbed (the count never wraps).
// Ports:
//   clk       in   1        system clock
//   rst       in   1        asynchronous, active-high reset (count -> 0)
//   i_inc     in   1        completed entry this edge
//   i_dec     in   1        completed exit this edge (never together with i_inc)
//   i_clear   in   1        synchronous clear, level-sampled
//   o_count   out  COUNT_W  current occupancy (registered)
//   o_full    out  1        o_count == MAX_COUNT
//   o_empty   out  1        o_count == 0
// -----------------------------------------------------------------------------
module ocupacion_contador #(
  parameter int unsigned COUNT_W   = 8,
  parameter int unsigned MAX_COUNT = 99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_inc,
  input  logic               i_dec,
  input  logic               i_clear,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

  logic [COUNT_W-1:0] r_count;

  // NOTE: state registers are assigned with non-blocking (<=) so every flop
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_VAL)) begin
      r_count <= r_count + ONE;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  // Flags come straight from the registered count, so they change together.
  assign o_count = r_count;
  assign o_full  = (r_count == MAX_VAL);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/contador_direccion_ir.sv
// -----------------------------------------------------------------------------
// contador_direccion_ir
// Direction sequencer for two debounced IR barriers at a doorway.
// A is the outer beam, B the inner one. Entry is the pattern walk
// 10 -> 11 -> 01 -> 00, exit is 01 -> 11 -> 10 -> 00 (s = {A,B}). Stepping back
// along the walk is allowed; backing out from the first step is silent.
// Anything else, or dwelling TIMEOUT_CYCLES in one crossing state, goes to ERR
// with a one-cycle error_pulse; ERR waits for both beams clear.
// Ports:
//   clk          in   1        system clock (50 MHz)
//   rst          in   1        asynchronous, active-high reset
//   sensor_a     in   1        debounced IR A (outer), 1 = beam broken
//   sensor_b     in   1        debounced IR B (inner), 1 = beam broken
//   clear        in   1        synchronous occupancy clear, level-sampled
//   count        out  COUNT_W  current occupancy (saturating 0..MAX_COUNT)
//   entry_pulse  out  1        one cycle per completed entry
//   exit_pulse   out  1        one cycle per completed exit
//   error_pulse  out  1        one cycle per invalid sequence or timeout
//   busy         out  1        state != IDLE
//   full         out  1        count == MAX_COUNT
//   empty        out  1        count == 0
// -----------------------------------------------------------------------------
module contador_direccion_ir
  import contador_direccion_ir_pkg::*;
#(
  parameter int unsigned COUNT_W        = 8,
  parameter int unsigned MAX_COUNT      = 99,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_1S,
  parameter int unsigned TMR_W          = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor_a,
  input  logic               sensor_b,
  input  logic               clear,
  output logic [COUNT_W-1:0] count,
  output logic               entry_pulse,
  output logic               exit_pulse,
  output logic               error_pulse,
  output logic               busy,
  output logic               full,
  output logic               empty
);

  // Timer value seen on the last permitted held cycle of a crossing state.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t           r_state;
  state_t           w_state_seq;   // next state from the pattern alone
  state_t           w_state_next;  // after the timeout override
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  sens_t            w_sens;
  logic             w_entry;
  logic             w_exit;
  logic             w_error;
  logic             w_held;
  logic             r_entry_pulse;
  logic             r_exit_pulse;
  logic             r_error_pulse;

  assign w_sens = sens_t'({sensor_a, sensor_b});

  // ---------------------------------------------------------------------------
  // Pattern decode. Each crossing state has one pattern that holds it, one or
  // two that move along the walk, and the rest are errors.
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before the
  // case; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_seq = r_state;
    w_entry     = 1'b0;
    w_exit      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        unique case (w_sens)
          S_A:    w_state_seq = ST_E1;
          S_B:    w_state_seq = ST_X1;
          S_AB:   w_state_seq = ST_ERR;
          S_NONE: w_state_seq = ST_IDLE;
        endcase
      end
      ST_E1: begin
        unique case (w_sens)
          S_A:    w_state_seq = ST_E1;
          S_AB:   w_state_seq = ST_E2;
          S_NONE: w_state_seq = ST_IDLE;  // backed out before reaching B
          S_B:    w_state_seq = ST_ERR;
        endcase
      end
      ST_E2: begin
        unique case (w_sens)
          S_AB:   w_state_seq = ST_E2;
          S_B:    w_state_seq = ST_E3;
          S_A:    w_state_seq = ST_E1;
          S_NONE: w_state_seq = ST_ERR;
        endcase
      end
      ST_E3: begin
        unique case (w_sens)
          S_B:    w_state_seq = ST_E3;
          S_AB:   w_state_seq = ST_E2;
          S_NONE: begin
            w_state_seq = ST_IDLE;
            w_entry     = 1'b1;
          end
          S_A:    w_state_seq = ST_ERR;
        endcase
      end
      ST_X1: begin
        unique case (w_sens)
          S_B:    w_state_seq = ST_X1;
          S_AB:   w_state_seq = ST_X2;
          S_NONE: w_state_seq = ST_IDLE;  // backed out before reaching A
          S_A:    w_state_seq = ST_ERR;
        endcase
      end
      ST_X2: begin
        unique case (w_sens)
          S_AB:   w_state_seq = ST_X2;
          S_A:    w_state_seq = ST_X3;
          S_B:    w_state_seq = ST_X1;
          S_NONE: w_state_seq = ST_ERR;
        endcase
      end
      ST_X3: begin
        unique case (w_sens)
          S_A:    w_state_seq = ST_X3;
          S_AB:   w_state_seq = ST_X2;
          S_NONE: begin
            w_state_seq = ST_IDLE;
            w_exit      = 1'b1;
          end
          S_B:    w_state_seq = ST_ERR;
        endcase
      end
      ST_ERR: begin
        if (w_sens == S_NONE) begin
          w_state_seq = ST_IDLE;
        end
      end
      default: w_state_seq = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dwell timeout and timer. A hold on the last permitted cycle turns into an
  // error; a pattern change always wins over the timeout. Completions are
  // never holds, so they are unaffected by the override.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_held       = is_crossing(r_state) && (w_state_seq == r_state);
    w_state_next = w_state_seq;
    if (w_held && (r_timer == TMR_LAST)) begin
      w_state_next = ST_ERR;
    end
    // Only entering ERR pulses; sitting in ERR stays quiet.
    w_error      = (w_state_next == ST_ERR) && (r_state != ST_ERR);
    w_timer_next = (w_state_next == r_state && is_crossing(r_state))
                   ? (r_timer + TMR_ONE) : '0;
  end

  // NOTE: rst is asynchronous so a reset mid-crossing drops the pending
  // sequence immediately; no pulse can leak out after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_entry_pulse <= 1'b0;
      r_exit_pulse  <= 1'b0;
      r_error_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_entry_pulse <= w_entry;
      r_exit_pulse  <= w_exit;
      r_error_pulse <= w_error;
    end
  end

  // The count moves on the same edge that registers entry/exit_pulse.
  ocupacion_contador #(
    .COUNT_W   (COUNT_W),
    .MAX_COUNT (MAX_COUNT)
  ) u_ocupacion (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_entry),
    .i_dec   (w_exit),
    .i_clear (clear),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  assign entry_pulse = r_entry_pulse;
  assign exit_pulse  = r_exit_pulse;
  assign error_pulse = r_error_pulse;
  assign busy        = (r_state != ST_IDLE);

endmodule
